// File: rtl/axi_lite_reg_selftest_master_pkg.sv
// +----------------------------------------------------------------------------+
// | Package  : axi_lite_reg_selftest_master_pkg                                |
// | Purpose  : Shared definitions for the AXI4-Lite register self-test master: |
// |            response codes, FSM state encoding, LFSR polynomial and the      |
// |            single-step LFSR function.                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package axi_lite_reg_selftest_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Taps 32,22,2,1 in right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WB   = 3'd2,
    ST_RA   = 3'd3,
    ST_RD   = 3'd4,
    ST_CHK  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // One Galois step: shift right, fold the polynomial in when bit 0 falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/selftest_lfsr_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : selftest_lfsr_gen                                               |
// | Purpose  : 32-bit Galois LFSR producing the per-register test pattern.     |
// |            Widened to 64 bits as {lfsr, ~lfsr}.                            |
// | Ports    : clk, rst_n (async active-low), load (reload SEED),              |
// |            step (advance one state), pattern (DW-wide test word)           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module selftest_lfsr_gen
  import axi_lite_reg_selftest_master_pkg::*;
#(
  parameter int          DW   = 32,
  parameter logic [31:0] SEED = 32'h0101_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  output logic [DW-1:0] pattern
);

  logic [31:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (load) begin
      r_lfsr <= SEED;
    end else if (step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  generate
    if (DW == 64) begin : g_dw64
      assign pattern = {r_lfsr, ~r_lfsr};
    end else begin : g_dw32
      assign pattern = r_lfsr;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/axi_lite_reg_selftest_master.sv
// +----------------------------------------------------------------------------+
// | Module   : axi_lite_reg_selftest_master                                    |
// | Purpose  : AXI4-Lite master that writes a pseudo-random pattern to         |
// |            NUM_REGS consecutive registers, reads each back, compares and   |
// |            reports pass/fail with first-error capture and channel timeout. |
// | Ports    : ACLK/ARESETN clock and async active-low reset; start pulse;     |
// |            status busy/done/pass/timeout/err_count; first-error capture    |
// |            fail_index/fail_expected/fail_actual; M_AXI_* AXI4-Lite master. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_lite_reg_selftest_master
  import axi_lite_reg_selftest_master_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h43C0_0000,
  parameter logic [31:0]                   SEED               = 32'h0101_FFFF,
  parameter int                            TIMEOUT_CYCLES     = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [7:0]                        err_count,
  output logic [7:0]                        fail_index,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     fail_expected,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     fail_actual,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int          AW       = C_M_AXI_ADDR_WIDTH;
  localparam int          DW       = C_M_AXI_DATA_WIDTH;
  localparam int          ADDR_LSB = $clog2(DW / 8);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_idx;
  logic [31:0]     r_tcnt;
  logic            r_awvalid, r_wvalid, r_arvalid, r_aw_done, r_w_done;
  logic [AW-1:0]   r_awaddr, r_araddr;
  logic [DW-1:0]   r_wdata, r_rdata;
  logic            r_busy, r_done, r_pass, r_timeout;
  logic [7:0]      r_err_count, r_fail_index;
  logic [DW-1:0]   r_fail_expected, r_fail_actual;

  logic            w_awvalid_nxt, w_wvalid_nxt, w_arvalid_nxt;
  logic            w_start_sweep, w_load_wr, w_load_ar, w_capture, w_step;
  logic            w_err, w_finish, w_timeout, w_wait_state;
  logic [DW-1:0]   w_err_actual, w_pattern;
  logic [AW-1:0]   w_reg_addr;
  logic            w_aw_hs, w_w_hs;

  assign w_reg_addr   = BASE_ADDR + (AW'(r_idx) << ADDR_LSB);
  assign w_aw_hs      = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs       = r_wvalid & M_AXI_WREADY;
  assign w_wait_state = (r_state == ST_WR) || (r_state == ST_WB) ||
                        (r_state == ST_RA) || (r_state == ST_RD);

  selftest_lfsr_gen #(
    .DW   (DW),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .load    (w_start_sweep),
    .step    (w_step),
    .pattern (w_pattern)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_arvalid_nxt = r_arvalid;
    w_start_sweep = 1'b0;
    w_load_wr     = 1'b0;
    w_load_ar     = 1'b0;
    w_capture     = 1'b0;
    w_step        = 1'b0;
    w_err         = 1'b0;
    w_err_actual  = '0;
    w_finish      = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt   = ST_WR;
          w_start_sweep = 1'b1;
        end
      end
      ST_WR: begin
        // First WR cycle registers address/data from the freshly stepped
        // index and LFSR; both VALIDs rise together on the following cycle.
        if (!r_awvalid && !r_wvalid && !r_aw_done && !r_w_done) begin
          w_load_wr     = 1'b1;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
        end else begin
          w_awvalid_nxt = r_awvalid & ~M_AXI_AWREADY;
          w_wvalid_nxt  = r_wvalid & ~M_AXI_WREADY;
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        if (M_AXI_BVALID) begin
          w_state_nxt   = ST_RA;
          w_load_ar     = 1'b1;
          w_arvalid_nxt = 1'b1;
          w_err         = (M_AXI_BRESP != RESP_OKAY);
        end
      end
      ST_RA: begin
        if (M_AXI_ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = ST_RD;
        end
      end
      ST_RD: begin
        if (M_AXI_RVALID) begin
          w_capture    = 1'b1;
          w_state_nxt  = ST_CHK;
          w_err        = (M_AXI_RRESP != RESP_OKAY);
          w_err_actual = M_AXI_RDATA;
        end
      end
      ST_CHK: begin
        w_err        = (r_rdata != w_pattern);
        w_err_actual = r_rdata;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end else begin
          w_step      = 1'b1;
          w_state_nxt = ST_WR;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Still waiting after TIMEOUT_CYCLES in this state: abandon the sweep
    if (w_wait_state && (w_state_nxt == r_state) && (r_tcnt == TMO_LAST)) begin
      w_state_nxt   = ST_DONE;
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_arvalid_nxt = 1'b0;
      w_load_wr     = 1'b0;
      w_timeout     = 1'b1;
      w_finish      = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_idx           <= '0;
      r_tcnt          <= '0;
      r_awvalid       <= 1'b0;
      r_wvalid        <= 1'b0;
      r_arvalid       <= 1'b0;
      r_aw_done       <= 1'b0;
      r_w_done        <= 1'b0;
      r_awaddr        <= '0;
      r_araddr        <= '0;
      r_wdata         <= '0;
      r_rdata         <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_timeout       <= 1'b0;
      r_err_count     <= '0;
      r_fail_index    <= '0;
      r_fail_expected <= '0;
      r_fail_actual   <= '0;
    end else begin
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_arvalid <= w_arvalid_nxt;

      if (w_state_nxt != r_state) r_tcnt <= '0;
      else if (w_wait_state)      r_tcnt <= r_tcnt + 32'd1;

      if (w_state_nxt != ST_WR) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end

      if (w_load_wr) begin
        r_awaddr <= w_reg_addr;
        r_wdata  <= w_pattern;
      end
      if (w_load_ar) r_araddr <= w_reg_addr;
      if (w_capture) r_rdata  <= M_AXI_RDATA;
      if (w_step)    r_idx    <= r_idx + 8'd1;

      if (w_start_sweep) begin
        r_idx           <= '0;
        r_busy          <= 1'b1;
        r_done          <= 1'b0;
        r_pass          <= 1'b0;
        r_timeout       <= 1'b0;
        r_err_count     <= '0;
        r_fail_index    <= '0;
        r_fail_expected <= '0;
        r_fail_actual   <= '0;
      end

      // err_count is still zero only until the first error, so it doubles
      // as the "first error" qualifier for the capture registers
      if (w_err) begin
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        if (r_err_count == 8'd0) begin
          r_fail_index    <= r_idx;
          r_fail_expected <= w_pattern;
          r_fail_actual   <= w_err_actual;
        end
      end

      if (w_timeout) r_timeout <= 1'b1;

      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (r_err_count == 8'd0) && !w_err && !w_timeout;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign err_count     = r_err_count;
  assign fail_index    = r_fail_index;
  assign fail_expected = r_fail_expected;
  assign fail_actual   = r_fail_actual;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = (r_state == ST_WB);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = (r_state == ST_RD);

endmodule

`default_nettype wire
